lzc: RTL and testbench

- Parameterized leading-zero counter / priority encoder, used by the FPU normalization paths (mantissa shift-amount computation).
- Reports the bit index of the most-significant set bit of `a`, plus a non-zero flag.
- Replaces the fixed-width `lzc_16`, `lzc_128` and `lzc_256` variants with one parameterized block.
- Combinational by default. An optional output register stage is available for timing-critical instances.

---
 rtl/lzc_pkg.sv | 22 ++
 rtl/lzc_leaf4.sv | 18 +
 rtl/lzc.sv | 75 +++++++
 tb/tb_lzc.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lzc_pkg.sv
// Width constants for the FPU normalization leading-zero counters, plus the
// log2 helper used to validate XLEN/XLOG pairs at elaboration.
package lzc_pkg;

  localparam int LZC16_XLEN  = 16;
  localparam int LZC16_XLOG  = 4;
  localparam int LZC128_XLEN = 128;
  localparam int LZC128_XLOG = 7;
  localparam int LZC256_XLEN = 256;
  localparam int LZC256_XLOG = 8;

  // Ceiling log2, valid for 1..512.
  function automatic int lzc_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i <= 9; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lzc_leaf4.sv
// 4-bit priority encoder: index of the highest set bit plus a non-zero flag.
module lzc_leaf4
  import lzc_pkg::*;
(
  input  logic [3:0] a,
  output logic [1:0] c,
  output logic       v
);

  always_comb begin
    v = |a;
    if (a[3])      c = 2'd3;
    else if (a[2]) c = 2'd2;
    else if (a[1]) c = 2'd1;
    else           c = 2'd0;
  end

endmodule

// File: rtl/lzc.sv
// Parameterized leading-one encoder: c = index of the MSB set in a (~c is the
// leading-zero count), v = |a. Optional output register when REG_OUT=1.
module lzc
  import lzc_pkg::*;
#(
  parameter int XLEN    = 256,
  parameter int XLOG    = 8,
  parameter int REG_OUT = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] a,
  output logic [XLOG-1:0] c,
  output logic            v
);

  localparam int NLEAF = XLEN / 4;
  localparam int NNODE = 2 * NLEAF - 1;

  if ((XLEN < 4) || (XLEN > 256) || ((XLEN & (XLEN - 1)) != 0)) begin : g_bad_xlen
    $error("lzc: XLEN must be a power of two in 4..256");
  end
  if (XLOG != lzc_log2(XLEN)) begin : g_bad_xlog
    $error("lzc: XLOG must equal log2(XLEN)");
  end

  // Heap-ordered tree: node n has upper-half child 2n+1 and lower-half child
  // 2n+2; node 0 is the root. Each node's index is zero-extended to XLOG bits.
  logic [XLOG-1:0] w_c [NNODE];
  logic            w_v [NNODE];

  for (genvar g = 0; g < NLEAF; g++) begin : g_leaf
    localparam int IDX  = NLEAF - 1 + g;
    localparam int BASE = 4 * (NLEAF - 1 - g);
    logic [1:0] w_lc;
    lzc_leaf4 u_leaf (
      .a (a[BASE +: 4]),
      .c (w_lc),
      .v (w_v[IDX])
    );
    assign w_c[IDX] = XLOG'(w_lc);
  end

  for (genvar g = 0; g < NLEAF - 1; g++) begin : g_merge
    localparam int D  = lzc_log2(g + 2) - 1;
    localparam int W  = XLOG - D;
    localparam int HI = 2 * g + 1;
    localparam int LO = 2 * g + 2;
    // Children carry W-1 significant bits; the upper half wins and sets bit W-1.
    assign w_v[g] = w_v[HI] | w_v[LO];
    assign w_c[g] = w_v[HI] ? (w_c[HI] | (XLOG'(1) << (W - 1))) : w_c[LO];
  end

  if (REG_OUT != 0) begin : g_reg
    logic [XLOG-1:0] r_c;
    logic            r_v;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_c <= '0;
        r_v <= 1'b0;
      end else begin
        r_c <= w_c[0];
        r_v <= w_v[0];
      end
    end
    assign c = r_c;
    assign v = r_v;
  end else begin : g_comb
    logic w_unused;
    assign w_unused = &{1'b0, clock, reset};
    assign c = w_c[0];
    assign v = w_v[0];
  end

endmodule

// File: tb/tb_lzc.sv
// Bench for lzc: three combinational widths plus a registered 128-bit
// instance, checked each cycle against a highest-set-bit search model.
module tb_lzc;
  import lzc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]  a16 = '0;
  logic [127:0] a128 = '0;
  logic [255:0] a256 = '0;
  logic [127:0] a128r = '0;
  logic [3:0]   c16;
  logic [6:0]   c128, c128r;
  logic [7:0]   c256;
  logic         v16, v128, v256, v128r;

  lzc #(.XLEN(LZC16_XLEN), .XLOG(LZC16_XLOG), .REG_OUT(0)) u_lzc16 (
    .clock(clk), .reset(rst_n), .a(a16), .c(c16), .v(v16));
  lzc #(.XLEN(LZC128_XLEN), .XLOG(LZC128_XLOG), .REG_OUT(0)) u_lzc128 (
    .clock(clk), .reset(rst_n), .a(a128), .c(c128), .v(v128));
  lzc #(.XLEN(LZC256_XLEN), .XLOG(LZC256_XLOG), .REG_OUT(0)) u_lzc256 (
    .clock(clk), .reset(rst_n), .a(a256), .c(c256), .v(v256));
  lzc #(.XLEN(LZC128_XLEN), .XLOG(LZC128_XLOG), .REG_OUT(1)) u_lzc128r (
    .clock(clk), .reset(rst_n), .a(a128r), .c(c128r), .v(v128r));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference: scan from the top bit down; -1 means no bit set.
  function automatic int msb(input logic [255:0] x, input int w);
    for (int i = w - 1; i >= 0; i--) if (x[i]) return i;
    return -1;
  endfunction

  function automatic int exp_c(input logic [255:0] x, input int w);
    int m;
    m = msb(x, w);
    return (m < 0) ? 0 : m;
  endfunction

  function automatic int exp_v(input logic [255:0] x, input int w);
    return (msb(x, w) >= 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Registered-instance scoreboard: input sampled at the last rising edge.
  logic [127:0] cap_a = '0;
  bit           cap_ok = 1'b0;
  always @(posedge clk) begin
    cap_a  = a128r;
    cap_ok = rst_n;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("c16", int'(c16), exp_c(256'(a16), 16));
      chk("v16", int'(v16), exp_v(256'(a16), 16));
      chk("c128", int'(c128), exp_c(256'(a128), 128));
      chk("v128", int'(v128), exp_v(256'(a128), 128));
      chk("c256", int'(c256), exp_c(a256, 256));
      chk("v256", int'(v256), exp_v(a256, 256));
      if (!rst_n || !cap_ok) begin
        chk("c128r_rst", int'(c128r), 0);
        chk("v128r_rst", int'(v128r), 0);
      end else begin
        chk("c128r", int'(c128r), exp_c(256'(cap_a), 128));
        chk("v128r", int'(v128r), exp_v(256'(cap_a), 128));
      end
    end
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r >> $urandom_range(0, 256);
  endfunction

  initial begin
    logic [7:0] nc256;
    logic [6:0] nc128;
    logic [3:0] nc16;
    int cnt16, cnt128, cnt256;

    // Pin the model with hand-computed values.
    chk("model_0123", exp_c(256'h0123, 16), 8);
    chk("model_one", exp_c(256'h1, 256), 0);
    chk("model_zero_v", exp_v(256'h0, 256), 0);

    // Registered instance held in reset.
    a128r = 128'(1) << 100;
    repeat (3) @(posedge clk);
    #2;
    chk("reg_hold_c", int'(c128r), 0);
    chk("reg_hold_v", int'(v128r), 0);
    chk_en = 1'b1;

    // Release reset just after an edge: result must not appear before the next edge.
    @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    chk("reg_not_before_c", int'(c128r), 0);
    chk("reg_not_before_v", int'(v128r), 0);
    @(posedge clk);
    #1;
    chk("reg_lat1_c", int'(c128r), 100);
    chk("reg_lat1_v", int'(v128r), 1);

    // Zero input on all widths.
    a16 = '0; a128 = '0; a256 = '0;
    @(negedge clk);
    chk("zero16_v", int'(v16), 0);
    chk("zero128_c", int'(c128), 0);
    chk("zero256_v", int'(v256), 0);

    // All ones: only the top bit matters.
    @(posedge clk); #1;
    a16 = '1; a128 = '1; a256 = '1;
    @(negedge clk);
    chk("ones16_c", int'(c16), 15);
    chk("ones128_c", int'(c128), 127);
    chk("ones256_c", int'(c256), 255);
    nc256 = ~c256;
    chk("ones256_nc", int'(nc256), 0);

    @(posedge clk); #1;
    a16 = 16'h0123;
    @(negedge clk);
    chk("h0123_c", int'(c16), 8);
    nc16 = ~c16;
    chk("h0123_nc", int'(nc16), 7);
    chk("h0123_v", int'(v16), 1);

    // Walking one with down-counters of leading zeros.
    cnt16 = 15; cnt128 = 127; cnt256 = 255;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk); #1;
      a256  = 256'(1) << k;
      a128  = 128'(1) << (k % 128);
      a16   = 16'(1) << (k % 16);
      a128r = 128'(1) << (k % 128);
      @(negedge clk);
      nc256 = ~c256; nc128 = ~c128; nc16 = ~c16;
      chk("walk256_nc", int'(nc256), cnt256);
      chk("walk128_nc", int'(nc128), cnt128);
      chk("walk16_nc", int'(nc16), cnt16);
      chk("walk256_v", int'(v256), 1);
      cnt256--;
      cnt128 = (cnt128 == 0) ? 127 : cnt128 - 1;
      cnt16  = (cnt16 == 0) ? 15 : cnt16 - 1;
    end

    // Random sweep; the compare process checks every cycle.
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk); #1;
      a256  = rand256();
      a128  = 128'(rand256());
      a16   = 16'($urandom) >> $urandom_range(0, 16);
      a128r = 128'(rand256());
    end

    // Reset asserted mid-cycle clears registered outputs without an edge.
    @(posedge clk); #1;
    a128r = 128'(1) << 120;
    @(posedge clk); #2;
    chk("reg_pre_rst_c", int'(c128r), 120);
    rst_n = 1'b0;
    #1;
    chk("reg_async_c", int'(c128r), 0);
    chk("reg_async_v", int'(v128r), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
